// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b one bit pair per clock,
// LSB first, and reports the WIDTH-bit difference plus the final borrow.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] aSh_q, aSh_d;
    logic [WIDTH-1:0] bSh_q, bSh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic bitA;
    logic bitB;
    logic diffBit;
    logic borrowNext;

    // All state, including the published result, is cleared immediately on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            aSh_q    <= '0;
            bSh_q    <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            count_q  <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            aSh_q    <= aSh_d;
            bSh_q    <= bSh_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            count_q  <= count_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
        end
    end

    // Next-state logic: accept in IDLE, one full-subtractor step per SHIFT edge,
    // publish diff/bout only on the last step so partial results never show
    always_comb begin
        state_d    = state_q;
        aSh_d      = aSh_q;
        bSh_d      = bSh_q;
        res_d      = res_q;
        borrow_d   = borrow_q;
        count_d    = count_q;
        diff_d     = diff_q;
        bout_d     = bout_q;

        bitA       = aSh_q[0];
        bitB       = bSh_q[0];
        diffBit    = bitA ^ bitB ^ borrow_q;
        borrowNext = (~bitA & bitB) | (~(bitA ^ bitB) & borrow_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    aSh_d    = a;
                    bSh_d    = b;
                    res_d    = '0;
                    borrow_d = 1'b0;
                    count_d  = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                aSh_d    = {1'b0, aSh_q[WIDTH-1:1]};
                bSh_d    = {1'b0, bSh_q[WIDTH-1:1]};
                res_d    = {diffBit, res_q[WIDTH-1:1]};
                borrow_d = borrowNext;
                count_d  = count_q + CW'(1);
                if (count_q == LAST) begin
                    diff_d  = {diffBit, res_q[WIDTH-1:1]};
                    bout_d  = borrowNext;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=16: stimulus
// pushes arithmetic expectations, per-instance monitors pop them on done.
module tb_serial_subtractor;

    typedef struct {
        logic [32:0] res;
        int          acc;
    } expect_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8, done8, bout8;
    logic [7:0]  diff8;

    logic        start16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        busy16, done16, bout16;
    logic [15:0] diff16;

    expect_t     q8[$];
    expect_t     q16[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [7:0]  lastDiff8 = '0;
    logic [15:0] lastDiff16 = '0;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    serial_subtractor #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .diff(diff16), .bout(bout16)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Edge counter used to measure accept-to-done latency
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Waits (bounded) for the selected instance to be idle at a negedge
    task automatic waitIdle(input int which);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (which == 8 && !busy8) return;
            if (which == 16 && !busy16) return;
        end
        checkOutput("idle_timeout", 64'd1, 64'd0);
    endtask

    // Drives one start pulse and queues the arithmetic expectation
    task automatic applyStimulus(input int which, input logic [31:0] av, input logic [31:0] bv);
        logic [8:0]  r8;
        logic [16:0] r16;
        if (which == 8) begin
            a8 = av[7:0]; b8 = bv[7:0]; start8 = 1'b1;
        end else begin
            a16 = av[15:0]; b16 = bv[15:0]; start16 = 1'b1;
        end
        @(posedge clk);
        #1;
        if (which == 8) begin
            start8 = 1'b0;
            r8 = {1'b0, av[7:0]} - {1'b0, bv[7:0]};
            q8.push_back('{33'(r8), cyc});
        end else begin
            start16 = 1'b0;
            r16 = {1'b0, av[15:0]} - {1'b0, bv[15:0]};
            q16.push_back('{33'(r16), cyc});
        end
    endtask

    // WIDTH=8 monitor: result on done, latency, and result stability while busy
    always @(negedge clk) begin
        expect_t e;
        if (rst_n && done8) begin
            if (q8.size() == 0) begin
                checkOutput("spurious_done8", 64'd1, 64'd0);
            end else begin
                e = q8.pop_front();
                checkOutput("diff8", 64'(diff8), 64'(e.res[7:0]));
                checkOutput("bout8", 64'(bout8), 64'(e.res[8]));
                checkOutput("latency8", 64'(cyc - e.acc), 64'd8);
            end
        end else if (rst_n && busy8) begin
            checkOutput("hold8", 64'(diff8), 64'(lastDiff8));
        end
        lastDiff8 = diff8;
    end

    // WIDTH=16 monitor, same checks as the 8-bit one
    always @(negedge clk) begin
        expect_t e;
        if (rst_n && done16) begin
            if (q16.size() == 0) begin
                checkOutput("spurious_done16", 64'd1, 64'd0);
            end else begin
                e = q16.pop_front();
                checkOutput("diff16", 64'(diff16), 64'(e.res[15:0]));
                checkOutput("bout16", 64'(bout16), 64'(e.res[16]));
                checkOutput("latency16", 64'(cyc - e.acc), 64'd16);
            end
        end else if (rst_n && busy16) begin
            checkOutput("hold16", 64'(diff16), 64'(lastDiff16));
        end
        lastDiff16 = diff16;
    end

    // Directed scenarios, reset abort, held start, then random traffic
    initial begin
        int busyCycles;
        logic [7:0] ha, hb;
        logic [8:0] hr;

        #12;
        checkOutput("rst_busy8", 64'(busy8), 64'd0);
        checkOutput("rst_done8", 64'(done8), 64'd0);
        checkOutput("rst_diff8", 64'(diff8), 64'd0);
        checkOutput("rst_bout8", 64'(bout8), 64'd0);
        checkOutput("rst_busy16", 64'(busy16), 64'd0);
        checkOutput("rst_diff16", 64'(diff16), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        waitIdle(8);
        applyStimulus(8, 32'h5A, 32'h13);
        busyCycles = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!busy8) break;
            busyCycles++;
        end
        checkOutput("busy_len8", 64'(busyCycles), 64'd9);

        waitIdle(8);
        applyStimulus(8, 32'h13, 32'h5A);

        waitIdle(8);
        applyStimulus(8, 32'h5A, 32'h13);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy8", 64'(busy8), 64'd0);
        checkOutput("abort_done8", 64'(done8), 64'd0);
        checkOutput("abort_diff8", 64'(diff8), 64'd0);
        checkOutput("abort_bout8", 64'(bout8), 64'd0);
        q8.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8, 32'h0F, 32'h0E);

        waitIdle(8);
        applyStimulus(8, 32'h00, 32'h01);
        waitIdle(8);
        applyStimulus(8, 32'hFF, 32'hFF);

        waitIdle(8);
        for (int k = 0; k < 30; k++) begin
            if (k > 0) @(negedge clk);
            ha = 8'($urandom);
            hb = 8'($urandom);
            a8 = ha;
            b8 = hb;
            start8 = 1'b1;
            @(posedge clk);
            #1;
            if (k % 10 == 0) begin
                hr = {1'b0, ha} - {1'b0, hb};
                q8.push_back('{33'(hr), cyc});
            end
        end
        @(negedge clk);
        start8 = 1'b0;

        fork
            begin
                for (int n = 0; n < 1000; n++) begin
                    waitIdle(8);
                    applyStimulus(8, $urandom, $urandom);
                end
            end
            begin
                for (int n = 0; n < 1000; n++) begin
                    waitIdle(16);
                    applyStimulus(16, $urandom, $urandom);
                end
            end
        join

        for (int i = 0; i < 100; i++) begin
            if (q8.size() == 0 && q16.size() == 0) break;
            @(negedge clk);
        end
        if (q8.size() != 0 || q16.size() != 0)
            checkOutput("drain_timeout", 64'(q8.size() + q16.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
